// File: rtl/digital_clock.sv
// 24-hour BCD wall clock, 00:00:00 to 23:59:59.
// One CLK_1Hz rising edge advances the time by one second; RESET clears
// all six digits at once, without waiting for a clock edge.
module digital_clock (
   input  logic       CLK_1Hz,
   input  logic       RESET,
   output logic [3:0] sec0,
   output logic [3:0] sec1,
   output logic [3:0] min0,
   output logic [3:0] min1,
   output logic [3:0] hour0,
   output logic [3:0] hour1
);

   logic [3:0] sec0_q, sec0_d;
   logic [3:0] sec1_q, sec1_d;
   logic [3:0] min0_q, min0_d;
   logic [3:0] min1_q, min1_d;
   logic [3:0] hour0_q, hour0_d;
   logic [3:0] hour1_q, hour1_d;

   // Terminal-count flags and the carry chain, taken straight from the
   // current digit values so that a full cascade settles in one edge.
   logic sec0_tc, sec1_tc, min0_tc, min1_tc;
   logic sec_carry, min_carry, day_wrap;

   // Terminal-count detection and carry propagation
   always_comb begin
      sec0_tc   = (sec0_q == 4'd9);
      sec1_tc   = (sec1_q == 4'd5);
      min0_tc   = (min0_q == 4'd9);
      min1_tc   = (min1_q == 4'd5);
      sec_carry = sec0_tc && sec1_tc;
      min_carry = sec_carry && min0_tc && min1_tc;
      day_wrap  = min_carry && (hour1_q == 4'd2) && (hour0_q == 4'd3);
   end

   // Next value of every digit; each digit moves only when its carry-in is set
   always_comb begin
      sec0_d  = sec0_tc ? 4'd0 : sec0_q + 4'd1;

      sec1_d  = sec1_q;
      if (sec0_tc) begin
         sec1_d = sec1_tc ? 4'd0 : sec1_q + 4'd1;
      end

      min0_d  = min0_q;
      if (sec_carry) begin
         min0_d = min0_tc ? 4'd0 : min0_q + 4'd1;
      end

      min1_d  = min1_q;
      if (sec_carry && min0_tc) begin
         min1_d = min1_tc ? 4'd0 : min1_q + 4'd1;
      end

      // Hours: 23 wraps to 00, otherwise plain two-digit decimal counting
      hour0_d = hour0_q;
      hour1_d = hour1_q;
      if (min_carry) begin
         if (day_wrap) begin
            hour0_d = 4'd0;
            hour1_d = 4'd0;
         end else if (hour0_q == 4'd9) begin
            hour0_d = 4'd0;
            hour1_d = hour1_q + 4'd1;
         end else begin
            hour0_d = hour0_q + 4'd1;
         end
      end
   end

   // Digit registers: asynchronous clear, advance once per second
   always_ff @(posedge CLK_1Hz or posedge RESET) begin
      if (RESET) begin
         sec0_q  <= 4'd0;
         sec1_q  <= 4'd0;
         min0_q  <= 4'd0;
         min1_q  <= 4'd0;
         hour0_q <= 4'd0;
         hour1_q <= 4'd0;
      end else begin
         sec0_q  <= sec0_d;
         sec1_q  <= sec1_d;
         min0_q  <= min0_d;
         min1_q  <= min1_d;
         hour0_q <= hour0_d;
         hour1_q <= hour1_d;
      end
   end

   assign sec0  = sec0_q;
   assign sec1  = sec1_q;
   assign min0  = min0_q;
   assign min1  = min1_q;
   assign hour0 = hour0_q;
   assign hour1 = hour1_q;

endmodule

// File: tb/tb_digital_clock.sv
// Self-checking bench for digital_clock: a seconds-of-day model compared on
// every edge, random asynchronous resets, and literal time checkpoints.
module tb_digital_clock;

   logic       clk = 1'b0;
   logic       RESET;
   logic [3:0] sec0, sec1, min0, min1, hour0, hour1;

   int tests = 0;
   int fails = 0;

   // Model state: elapsed seconds of the day, valid once a reset has been seen
   int model_secs  = 0;
   bit model_valid = 1'b0;

   digital_clock dut (
      .CLK_1Hz (clk),
      .RESET   (RESET),
      .sec0    (sec0),
      .sec1    (sec1),
      .min0    (min0),
      .min1    (min1),
      .hour0   (hour0),
      .hour1   (hour1)
   );

   // 10-unit clock period; one period stands for one second
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   function automatic logic [23:0] dut_time();
      return {hour1, hour0, min1, min0, sec1, sec0};
   endfunction

   // Seconds of the day -> packed BCD hh:mm:ss
   function automatic logic [23:0] to_bcd(input int s);
      int h, m, x;
      h = s / 3600;
      m = (s / 60) % 60;
      x = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h:%h:%h required %h:%h:%h", name,
                  act[23:16], act[15:8], act[7:0], exp[23:16], exp[15:8], exp[7:0]);
      end
   endtask

   task automatic show(input string tag);
      $display("[TB] %s t=%0t  %0d %0d:%0d %0d:%0d %0d", tag, $time,
               hour1, hour0, min1, min0, sec1, sec0);
   endtask

   // Per-edge compare against the model, plus a digit-legality check
   always @(posedge clk) begin
      logic legal;
      #1;
      if (RESET) begin
         model_secs  = 0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         model_secs = (model_secs + 1) % 86400;
      end
      if (model_valid) begin
         check("edge", dut_time(), to_bcd(model_secs));
         legal = (sec0 <= 4'd9) && (sec1 <= 4'd5) && (min0 <= 4'd9) && (min1 <= 4'd5) &&
                 (hour1 <= 4'd2) && (hour0 <= ((hour1 == 4'd2) ? 4'd3 : 4'd9));
         tests++;
         if (!legal) begin
            fails++;
            $display("[TB] FAIL range: got %h:%h:%h required legal BCD time",
                     dut_time()[23:16], dut_time()[15:8], dut_time()[7:0]);
         end
         if (model_secs % 600 == 0) show("edge");
      end
   end

   // Advance n edges, then settle at the following falling edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Raise RESET between edges and confirm the clear is immediate
   task automatic async_reset(input string name);
      @(posedge clk);
      #($urandom_range(2, 3));
      RESET = 1'b1;
      #1;
      check(name, dut_time(), 24'h000000);
      show(name);
   endtask

   initial begin
      int run;
      int hold;
      RESET = 1'b1;
      tick(1);
      check("reset_hold", dut_time(), 24'h000000);
      RESET = 1'b0;

      // Ten edges after release
      tick(10);
      check("ten_edges", dut_time(), 24'h000010);
      show("ten_edges");

      // Random runs interrupted by random asynchronous resets
      for (int i = 0; i < 6; i++) begin
         run  = $urandom_range(1, 100);
         hold = $urandom_range(1, 5);
         tick(run);
         async_reset("rand_reset");
         tick(hold);
         check("rand_reset_held", dut_time(), 24'h000000);
         RESET = 1'b0;
      end

      // 00:12:34, reset mid-count, hold for five edges, then restart
      tick(754);
      check("t_001234", dut_time(), 24'h001234);
      show("t_001234");
      async_reset("reset_001234");
      tick(5);
      check("reset_held_5", dut_time(), 24'h000000);
      RESET = 1'b0;
      tick(1);
      check("restart", dut_time(), 24'h000001);

      // Fresh day from reset for the long checkpoints
      RESET = 1'b1;
      tick(1);
      RESET = 1'b0;
      tick(60);
      check("t_000100", dut_time(), 24'h000100);
      show("t_000100");
      tick(3600 - 60);
      check("t_010000", dut_time(), 24'h010000);
      show("t_010000");
      tick(36000 - 3600);
      check("t_100000", dut_time(), 24'h100000);
      show("t_100000");
      tick(86399 - 36000);
      check("t_235959", dut_time(), 24'h235959);
      show("t_235959");
      tick(1);
      check("day_wrap", dut_time(), 24'h000000);
      show("day_wrap");
      tick(1);
      check("after_wrap", dut_time(), 24'h000001);
      show("after_wrap");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/digital_clock.md
DIGITAL_CLOCK -- requirements
Module: digital_clock

Interface
REQ-001 Parameters: none; all limits are fixed (24-hour format, BCD digits).
REQ-002 Port order, positional-instantiation compatible: CLK_1Hz, RESET, sec0, sec1, min0, min1, hour0, hour1.
REQ-003 CLK_1Hz  input  1  single clock; one rising edge = one elapsed second.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 sec0  output  4  seconds units digit, BCD 0-9.
REQ-006 sec1  output  4  seconds tens digit, BCD 0-5.
REQ-007 min0  output  4  minutes units digit, BCD 0-9.
REQ-008 min1  output  4  minutes tens digit, BCD 0-5.
REQ-009 hour0  output  4  hours units digit, BCD 0-9 (0-3 when hour1=2).
REQ-010 hour1  output  4  hours tens digit, BCD 0-2.
REQ-011 All outputs are registered, driven directly from state flops, with no combinational path from inputs.

Function
REQ-012 The block is a 24-hour clock, 00:00:00 to 23:59:59, and advances by exactly one second on every CLK_1Hz rising edge while RESET is low.
REQ-013 Latency: the first rising edge after RESET deasserts produces 00:00:01; outputs change only on rising edges.
REQ-014 sec0 increments every edge; at 9 it wraps to 0 and carries to sec1.
REQ-015 sec1 increments on a sec0 carry; at 5 with a carry it wraps to 0 and carries to min0 (59 -> 00).
REQ-016 min0 and min1 follow the same rules as sec0 and sec1; minute 59 plus a carry gives 00 and carries to hours.
REQ-017 hour0 increments on a minute carry; at 9 it wraps to 0 and increments hour1.
REQ-018 Day wrap: at 23:59:59 the next edge gives 00:00:00 (all six digits 0 together); hour 23 with a carry never gives 24.
REQ-019 All digits cascading in one edge update in that same edge with no intermediate states; for example, 09:59:59 -> 10:00:00 and 19:59:59 -> 20:00:00.
REQ-020 Digits stay within their legal BCD ranges at all times; illegal codes (A-F, sec1/min1 > 5, hour > 23) are unreachable from reset.
REQ-021 Carries are computed combinationally from current digit values (terminal-count detection), not delayed by a cycle.

Reset
REQ-022 When RESET rises, all six outputs go to 0 immediately, independent of CLK_1Hz.
REQ-023 While RESET is high, outputs hold 00:00:00 and clock edges are ignored.
REQ-024 Reset asserted mid-count (any time value) aborts counting and returns to 00:00:00; counting restarts from 00:00:00 on the first edge after deassertion.
REQ-025 The state before the first reset is undefined; a bench applies reset before checking.

Verification
REQ-026 Reset for 1 cycle, release, then 10 edges -> hour1..sec0 = 0 0:0 0:1 0.
REQ-027 Release, then 60 edges -> 00:01:00; 3600 edges -> 01:00:00; 36000 edges -> 10:00:00.
REQ-028 Release, then 86399 edges -> 23:59:59; edge 86400 -> 00:00:00; edge 86401 -> 00:00:01.
REQ-029 Count to 00:12:34 (754 edges), assert RESET between edges -> outputs 00:00:00 before the next edge; hold reset for 5 edges -> still 00:00:00.
REQ-030 A self-checking reference model compares all digits every edge over at least 100000 edges, including the 09->10, 19->20, 23->00 and x9:59:59 cascades -> zero mismatches and no out-of-range digit.
REQ-031 Sample outputs on every rising edge and print them as "hour1 hour0:min1 min0:sec1 sec0" for the log.
